mii_frame_scheduler: RTL and testbench
======================================

MII_FRAME_SCHEDULER -- requirements
Module: mii_frame_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of frame requesters (2..8).
REQ-002 SHALL have parameter PAYLOAD_MAX_SIZE, default 1500: largest legal payload length in bytes.
REQ-003 SHALL have parameter IFG_CYCLES, default 2: idle clocks enforced after each frame completes.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 512: maximum clocks allowed from o_start to i_gen_done.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port i_req, input, N_REQ: level request per requester; held until o_ack.
REQ-008 SHALL have ports i_dest_address, i_src_address, i_eth_type, i_payload_length, inputs, N_REQ x 48/48/16/16: per-requester frame fields, stable while i_req is high.
REQ-009 SHALL have port o_ack, output, N_REQ: one-cycle pulse when the request is accepted or rejected.
REQ-010 SHALL have port o_done, output, N_REQ: one-cycle pulse when the granted frame completes.
REQ-011 SHALL have port o_err, output, N_REQ: one-cycle pulse on a length reject or a timeout.
REQ-012 SHALL have ports o_start, output, 1, plus o_dest_address, o_src_address, o_eth_type and o_payload_length, outputs, 48/48/16/16: the frame-generator command.
REQ-013 SHALL have port i_gen_done, input, 1: the generator's frame-done pulse.
REQ-014 SHALL have port o_busy, output, 1, and port o_grant_id, output, $clog2(N_REQ): the state is not IDLE, and the index of the current owner.

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT_DONE and IFG.
REQ-016 In IDLE with any i_req high, SHALL round-robin select the first requester at or after rr_ptr, latch its fields and index, and enter START on the next clock.
REQ-017 In START, SHALL raise o_ack[id] for one cycle; if the latched length is 0 or greater than PAYLOAD_MAX_SIZE, SHALL also raise o_err[id], not pulse o_start, and return to IDLE.
REQ-018 In START with a legal length, SHALL raise o_start for exactly one cycle together with o_ack[id], then enter WAIT_DONE; latency from i_req sampled in IDLE to o_start is 2 clocks.
REQ-019 SHALL hold the o_* command fields constant from START until the scheduler next leaves IFG or IDLE.
REQ-020 In WAIT_DONE, SHALL count clocks; i_gen_done SHALL pulse o_done[id] and enter IFG.
REQ-021 In WAIT_DONE, when the count reaches TIMEOUT_CYCLES without i_gen_done, SHALL pulse o_err[id] and enter IFG.
REQ-022 If i_gen_done arrives in the same cycle the timeout expires, done SHALL win: o_done is pulsed and o_err is not.
REQ-023 SHALL ignore i_gen_done outside WAIT_DONE.
REQ-024 SHALL remain in IFG exactly IFG_CYCLES clocks (IFG_CYCLES of 0 returns to IDLE on the next clock), then return to IDLE.
REQ-025 SHALL set rr_ptr to (id+1) mod N_REQ on every accept or reject, so a continuously requesting channel cannot starve the others.
REQ-026 A request dropped before its o_ack SHALL NOT be served; a request still high after its o_ack SHALL be treated as a new request.
REQ-027 SHALL size counters to their parameter maximum, with no wrap-around inside a state.

Reset
REQ-028 On i_rst, SHALL enter IDLE with rr_ptr=0 and counters=0.
REQ-029 On i_rst, all outputs SHALL be 0, including the command fields and o_grant_id.
REQ-030 Reset asserted mid-frame SHALL abort silently, with no o_done or o_err pulse.
REQ-031 A late i_gen_done arriving after reset SHALL be ignored.

Structure
REQ-032 SHALL place the FSM state enum, a frame-command struct {dest, src, eth_type, payload_length} and the width constants in a shared package, mii_sched_pkg.
REQ-033 SHALL implement the round-robin arbiter as one sub-module, rr_arbiter (request vector and pointer in; one-hot grant and index out).
REQ-034 SHALL implement the FSM, counters and command latches in the top level.

Verification
REQ-035 A bench SHALL cover: i_req=4'b0001 with length 64, i_gen_done 10 clocks after o_start -> o_start 2 clocks after the request, fields matched, o_done[0] pulsed, o_busy low after IFG_CYCLES.
REQ-036 A bench SHALL cover: i_req=4'b1111 held, instant done -> grants in order 0,1,2,3,0, and the next o_start no sooner than IFG_CYCLES+2 clocks after each done.
REQ-037 A bench SHALL cover: length 1501 or 0 on requester 2 -> o_ack[2] and o_err[2] in the same cycle, no o_start, back to IDLE.
REQ-038 A bench SHALL cover: i_gen_done never asserted -> o_err[id] exactly TIMEOUT_CYCLES clocks after o_start; i_gen_done on the expiry cycle -> o_done only.
REQ-039 A bench SHALL cover: i_rst pulsed during WAIT_DONE, then i_gen_done -> all outputs 0, no done or err pulses, the next grant goes to requester 0.

Source files
------------

// File: rtl/mii_sched_pkg.sv
// Shared types and constants for the MII frame scheduler.
// Holds the FSM encoding, the frame command bundle and the length check.
package mii_sched_pkg;

    localparam int ADDR_W = 48;
    localparam int TYPE_W = 16;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        IFG
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [ADDR_W-1:0] src;
        logic [TYPE_W-1:0] eth_type;
        logic [LEN_W-1:0]  payload_length;
    } frame_cmd_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first active request at or after ptr wins.
// Purely combinational; the owner of ptr decides fairness.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mii_frame_scheduler.sv
// Arbitrates N requesters onto one MII frame generator.
// Latches the winner's command, supervises completion and enforces the IFG.
module mii_frame_scheduler
    import mii_sched_pkg::*;
#(
    parameter int N_REQ            = 4,
    parameter int PAYLOAD_MAX_SIZE = 1500,
    parameter int IFG_CYCLES       = 2,
    parameter int TIMEOUT_CYCLES   = 512
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_dest_address,
    input  logic [N_REQ*ADDR_W-1:0]   i_src_address,
    input  logic [N_REQ*TYPE_W-1:0]   i_eth_type,
    input  logic [N_REQ*LEN_W-1:0]    i_payload_length,
    output logic [N_REQ-1:0]          o_ack,
    output logic [N_REQ-1:0]          o_done,
    output logic [N_REQ-1:0]          o_err,
    output logic                      o_start,
    output logic [ADDR_W-1:0]         o_dest_address,
    output logic [ADDR_W-1:0]         o_src_address,
    output logic [TYPE_W-1:0]         o_eth_type,
    output logic [LEN_W-1:0]          o_payload_length,
    input  logic                      i_gen_done,
    output logic                      o_busy,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id
);

    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    state_t           state;
    frame_cmd_t       cmd;
    frame_cmd_t       sel;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    id;
    logic [N_REQ-1:0] own;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    gidx;
    logic             gvalid;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req   (i_req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .valid (gvalid)
    );

    always_comb begin
        sel.dest           = i_dest_address[int'(gidx)*ADDR_W +: ADDR_W];
        sel.src            = i_src_address[int'(gidx)*ADDR_W +: ADDR_W];
        sel.eth_type       = i_eth_type[int'(gidx)*TYPE_W +: TYPE_W];
        sel.payload_length = i_payload_length[int'(gidx)*LEN_W +: LEN_W];
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cmd     <= '0;
            rr_ptr  <= '0;
            id      <= '0;
            own     <= '0;
            cnt     <= '0;
            o_ack   <= '0;
            o_done  <= '0;
            o_err   <= '0;
            o_start <= 1'b0;
        end else begin
            o_ack   <= '0;
            o_done  <= '0;
            o_err   <= '0;
            o_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (gvalid) begin
                        cmd   <= sel;
                        id    <= gidx;
                        own   <= grant;
                        state <= START;
                    end
                end
                START: begin
                    cnt <= '0;
                    // A requester that let go before its ack is simply forgotten
                    if ((i_req & own) == '0) begin
                        state <= IDLE;
                    end else begin
                        o_ack  <= own;
                        rr_ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
                        if (len_ok(cmd.payload_length, PAYLOAD_MAX_SIZE)) begin
                            o_start <= 1'b1;
                            state   <= WAIT_DONE;
                        end else begin
                            o_err <= own;
                            state <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (i_gen_done) begin
                        o_done <= own;
                        cnt    <= '0;
                        state  <= IFG;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        o_err <= own;
                        cnt   <= '0;
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IFG: begin
                    if (IFG_CYCLES == 0 || cnt == CW'(IFG_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy           = (state != IDLE);
    assign o_grant_id       = id;
    assign o_dest_address   = cmd.dest;
    assign o_src_address    = cmd.src;
    assign o_eth_type       = cmd.eth_type;
    assign o_payload_length = cmd.payload_length;

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// Self-checking bench for mii_frame_scheduler.
// Vector table plus scoreboard of expected acks/commands.
module tb_mii_frame_scheduler;

    localparam int N    = 4;
    localparam int PMAX = 1500;
    localparam int IFG  = 2;
    localparam int T    = 512;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*48-1:0] i_dest_address;
    logic [N*48-1:0] i_src_address;
    logic [N*16-1:0] i_eth_type;
    logic [N*16-1:0] i_payload_length;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_done;
    logic [N-1:0]    o_err;
    logic            o_start;
    logic [47:0]     o_dest_address;
    logic [47:0]     o_src_address;
    logic [15:0]     o_eth_type;
    logic [15:0]     o_payload_length;
    logic            i_gen_done;
    logic            o_busy;
    logic [1:0]      o_grant_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int len;
        int dly;
        bit st;
    } vec_t;

    typedef struct {
        int          id;
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        logic [15:0] l;
        bit          st;
    } exp_t;

    exp_t        sbq[$];
    logic [47:0] fd[N];
    logic [47:0] fs[N];
    logic [15:0] ft[N];
    logic [15:0] fl[N];

    mii_frame_scheduler #(
        .N_REQ(N),
        .PAYLOAD_MAX_SIZE(PMAX),
        .IFG_CYCLES(IFG),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .i_rst(i_rst),
        .i_req(i_req),
        .i_dest_address(i_dest_address),
        .i_src_address(i_src_address),
        .i_eth_type(i_eth_type),
        .i_payload_length(i_payload_length),
        .o_ack(o_ack),
        .o_done(o_done),
        .o_err(o_err),
        .o_start(o_start),
        .o_dest_address(o_dest_address),
        .o_src_address(o_src_address),
        .o_eth_type(o_eth_type),
        .o_payload_length(o_payload_length),
        .i_gen_done(i_gen_done),
        .o_busy(o_busy),
        .o_grant_id(o_grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic chk_ge(input string nm, input int got, input int lo);
        total++;
        if (got < lo) begin
            bad++;
            $display("FAIL %s got=%0d want>=%0d", nm, got, lo);
        end
    endtask

    task automatic set_fields(input int id, input int len);
        fd[id] = {16'($urandom), $urandom};
        fs[id] = {16'($urandom), $urandom};
        ft[id] = 16'($urandom);
        fl[id] = 16'(len);
        i_dest_address[id*48 +: 48]   = fd[id];
        i_src_address[id*48 +: 48]    = fs[id];
        i_eth_type[id*16 +: 16]       = ft[id];
        i_payload_length[id*16 +: 16] = fl[id];
    endtask

    task automatic push_exp(input int id, input bit st);
        exp_t e;
        e.id = id;
        e.d  = fd[id];
        e.s  = fs[id];
        e.t  = ft[id];
        e.l  = fl[id];
        e.st = st;
        sbq.push_back(e);
    endtask

    // Scoreboard: every ack must match the oldest expected grant.
    always @(negedge clk) begin
        exp_t e;
        if (!i_rst && (o_ack != '0 || o_start)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_ack", 64'(o_ack), 64'(0));
            end else begin
                e = sbq.pop_front();
                chk("sb_ack", 64'(o_ack), 64'(oh(e.id)));
                chk("sb_grant_id", 64'(o_grant_id), 64'(e.id));
                chk("sb_start", 64'(o_start), 64'(e.st));
                chk("sb_err", 64'(o_err), e.st ? 64'(0) : 64'(oh(e.id)));
                if (e.st) begin
                    chk("sb_dest", 64'(o_dest_address), 64'(e.d));
                    chk("sb_src", 64'(o_src_address), 64'(e.s));
                    chk("sb_type", 64'(o_eth_type), 64'(e.t));
                    chk("sb_len", 64'(o_payload_length), 64'(e.l));
                end
            end
        end
    end

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_ack == '0 && n < 20);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (o_busy && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic txn(input vec_t v);
        int n;
        set_fields(v.id, v.len);
        push_exp(v.id, v.st);
        i_req[v.id] = 1'b1;
        wait_ack(n);
        chk("ack_latency", 64'(n), 64'(2));
        i_req[v.id] = 1'b0;
        if (!v.st) begin
            chk("reject_idle", 64'(o_busy), 64'(0));
            return;
        end
        n = 0;
        while (n < T + 8) begin
            i_gen_done = (v.dly >= 0 && n == v.dly);
            @(negedge clk);
            n++;
            if (o_done != '0 || o_err != '0) break;
        end
        i_gen_done = 1'b0;
        chk("end_latency", 64'(n), 64'((v.dly >= 0) ? v.dly + 1 : T));
        chk("end_done", 64'(o_done), (v.dly >= 0) ? 64'(oh(v.id)) : 64'(0));
        chk("end_err", 64'(o_err), (v.dly >= 0) ? 64'(0) : 64'(oh(v.id)));
        wait_idle(n);
        chk("ifg_len", 64'(n), 64'(IFG));
    endtask

    initial begin
        vec_t vt[9];
        int   n;
        int   order[5];
        logic seen;

        vt = '{
            '{0, 64,    10,    1'b1},
            '{2, 1501,  -1,    1'b0},
            '{2, 0,     -1,    1'b0},
            '{1, 1500,  0,     1'b1},
            '{3, 1,     3,     1'b1},
            '{0, 46,    -1,    1'b1},
            '{1, 100,   T - 1, 1'b1},
            '{3, 65535, -1,    1'b0},
            '{2, 1500,  1,     1'b1}
        };
        order = '{0, 1, 2, 3, 0};

        i_rst            = 1'b1;
        i_req            = '0;
        i_gen_done       = 1'b0;
        i_dest_address   = '0;
        i_src_address    = '0;
        i_eth_type       = '0;
        i_payload_length = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 64'({o_ack, o_done, o_err, o_start, o_busy, o_grant_id}), 64'(0));
        chk("rst_addr", 64'(o_dest_address | o_src_address), 64'(0));
        chk("rst_type_len", 64'({o_eth_type, o_payload_length}), 64'(0));
        i_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) txn(vt[i]);

        // Request withdrawn while the scheduler is still in START
        i_req[1] = 1'b1;
        @(negedge clk);
        i_req[1] = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | (o_ack != '0) | o_start;
        end
        chk("drop_no_ack", 64'(seen), 64'(0));
        chk("drop_idle", 64'(o_busy), 64'(0));

        // All four requesting continuously: fair rotation from pointer 0
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < N; i++) set_fields(i, 64 + 10 * i);
        for (int g = 0; g < 5; g++) push_exp(order[g], 1'b1);
        i_req = '1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (!o_start && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_start_seen", 64'(o_start), 64'(1));
            if (g > 0) chk_ge("rr_ifg_gap", n, IFG + 2);
            if (g == 4) i_req = '0;
            i_gen_done = 1'b1;
            @(negedge clk);
            i_gen_done = 1'b0;
            chk("rr_done", 64'(o_done), 64'(oh(order[g])));
        end
        wait_idle(n);

        // Reset in the middle of a frame, then a stale generator done
        set_fields(2, 200);
        push_exp(2, 1'b1);
        i_req[2] = 1'b1;
        wait_ack(n);
        i_req[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(o_busy), 64'(1));
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_flags", 64'({o_ack, o_done, o_err, o_start, o_busy, o_grant_id}), 64'(0));
        chk("mid_rst_cmd", 64'(o_dest_address | o_src_address | 48'(o_payload_length)), 64'(0));
        i_rst      = 1'b0;
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            seen = seen | (o_done != '0) | (o_err != '0) | o_busy;
            @(negedge clk);
        end
        chk("late_done_ignored", 64'(seen), 64'(0));

        set_fields(0, 300);
        set_fields(2, 400);
        push_exp(0, 1'b1);
        push_exp(2, 1'b1);
        i_req = 4'b0101;
        wait_ack(n);
        chk("post_rst_grant", 64'(o_grant_id), 64'(0));
        i_req[0]   = 1'b0;
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        chk("post_rst_done0", 64'(o_done), 64'(oh(0)));
        wait_ack(n);
        i_req[2]   = 1'b0;
        i_gen_done = 1'b1;
        @(negedge clk);
        i_gen_done = 1'b0;
        chk("post_rst_done2", 64'(o_done), 64'(oh(2)));
        wait_idle(n);
        chk("final_idle", 64'(o_busy), 64'(0));
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
